// File: rtl/add_operand_seq.sv
// add_operand_seq: collects two operand beats (A then B), presents them
// bit-interleaved to an external combinational adder, captures the sum and
// hands it downstream with a valid/ready handshake.
// Optional feature: define ADD_OPERAND_SEQ_SAT_EN to clamp a carried-out sum
// to the largest WIDTH-bit value and raise out_sat.
module add_operand_seq #(
    parameter int WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 abort,
    output logic [2*WIDTH-1:0]   adder_in,
    input  logic [WIDTH:0]       adder_sum,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH:0]       out_data,
    output logic                 out_sat,
    output logic [7:0]           op_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_B = 2'd1,
        EVAL   = 2'd2,
        OUT    = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH:0]   res_reg;
    logic [7:0]       cnt_reg;
    logic             in_fire;
    logic             out_fire;
    logic             eval_cap;

    // Clamp a carried-out sum to the largest representable WIDTH-bit value
    // when saturation is built in; otherwise pass the sum through untouched.
    function automatic logic [WIDTH:0] saturate(input logic [WIDTH:0] s);
`ifdef ADD_OPERAND_SEQ_SAT_EN
        if (s[WIDTH])
            return {1'b0, {WIDTH{1'b1}}};
        return s;
`else
        return s;
`endif
    endfunction

    // Handshake qualifiers; abort blocks both sides in the cycle it is high.
    always_comb begin
        in_ready = ((state == IDLE) || (state == WAIT_B)) && !abort;
        in_fire  = in_valid && in_ready;
        out_fire = (state == OUT) && out_ready && !abort;
        eval_cap = (state == EVAL) && !abort;
    end

    // Next-state logic; abort returns to IDLE from anywhere.
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (in_fire)  state_nxt = WAIT_B;
                WAIT_B:  if (in_fire)  state_nxt = EVAL;
                EVAL:                  state_nxt = OUT;
                OUT:     if (out_fire) state_nxt = IDLE;
                default:               state_nxt = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Operand registers: first accepted beat is A, second is B.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
        end else begin
            if (in_fire && (state == IDLE))
                a_reg <= in_data;
            if (in_fire && (state == WAIT_B))
                b_reg <= in_data;
        end
    end

    // Adder bus is driven purely from the operand registers, bit-interleaved.
    always_comb begin
        adder_in = '0;
        for (int i = 0; i < WIDTH; i++) begin
            adder_in[2*i]   = a_reg[i];
            adder_in[2*i+1] = b_reg[i];
        end
    end

    // Result capture at the closing edge of EVAL; held until the transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            res_reg <= '0;
        else if (eval_cap)
            res_reg <= saturate(adder_sum);
    end

`ifdef ADD_OPERAND_SEQ_SAT_EN
    logic sat_reg;

    // Saturation flag captured alongside the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sat_reg <= 1'b0;
        else if (eval_cap)
            sat_reg <= adder_sum[WIDTH];
    end

    assign out_sat = sat_reg;
`else
    assign out_sat = 1'b0;
`endif

    // Completed-transfer counter, wraps naturally at 8 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_reg <= 8'd0;
        else if (out_fire)
            cnt_reg <= cnt_reg + 8'd1;
    end

    assign out_valid = (state == OUT);
    assign out_data  = res_reg;
    assign op_cnt    = cnt_reg;

endmodule

// File: tb/tb_add_operand_seq.sv
// Self-checking bench for add_operand_seq (WIDTH=12) with a behavioural
// adder attached to adder_in/adder_sum and a result scoreboard.
module tb_add_operand_seq;

    localparam int W = 12;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [W-1:0]      in_data;
    logic              abort;
    logic [2*W-1:0]    adder_in;
    logic [W:0]        adder_sum;
    logic              out_valid;
    logic              out_ready;
    logic [W:0]        out_data;
    logic              out_sat;
    logic [7:0]        op_cnt;

    int checks   = 0;
    int failures = 0;

    logic [W:0] exp_q[$];

    add_operand_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .abort     (abort),
        .adder_in  (adder_in),
        .adder_sum (adder_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .op_cnt    (op_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural downstream adder: undo the interleave and add.
    logic [W-1:0] ta, tb_op;
    always_comb begin
        ta    = '0;
        tb_op = '0;
        for (int i = 0; i < W; i++) begin
            ta[i]    = adder_in[2*i];
            tb_op[i] = adder_in[2*i+1];
        end
        adder_sum = {1'b0, ta} + {1'b0, tb_op};
    end

    // Expected {sat, data} for a pair of operands.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
`ifdef ADD_OPERAND_SEQ_SAT_EN
        if (s[W])
            return {1'b1, 1'b0, {W{1'b1}}};
`endif
        return {1'b0, s};
    endfunction

    logic [W+1:0] exp_q2[$];

    // Scoreboard: compare every completed output transfer with the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !abort) begin
            checks++;
            if (exp_q2.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected got data=%h sat=%b required no output", out_data, out_sat);
            end else begin
                logic [W+1:0] e;
                e = exp_q2.pop_front();
                if ({out_sat, out_data} !== e) begin
                    failures++;
                    $display("FAIL sb_result got sat=%b data=%h required sat=%b data=%h",
                             out_sat, out_data, e[W+1], e[W:0]);
                end
            end
        end
    end

    task automatic put_beat(input logic [W-1:0] d);
        bit ok;
        ok       = 0;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL beat_timeout got in_ready=0 required in_ready=1 within 50 cycles");
        end
    endtask

    task automatic send_pair(input logic [W-1:0] a, input logic [W-1:0] b);
        put_beat(a);
        put_beat(b);
        exp_q2.push_back(model(a, b));
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        abort     = 1'b0;
        out_ready = 1'b0;
        #3;
        checks++;
        if ({out_valid, out_sat, out_data, op_cnt, adder_in} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got v=%b s=%b d=%h c=%h ai=%h required all 0",
                     out_valid, out_sat, out_data, op_cnt, adder_in);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got %b required 1", in_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic;
        out_ready = 1'b1;
        send_pair(12'h0FF, 12'h001);
        checks++;
        if (adder_in !== 24'h005557) begin
            failures++;
            $display("FAIL basic_adder_in got %h required 005557", adder_in);
        end
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_eval got v=%b rdy=%b required v=0 rdy=0", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 13'h0100) begin
            failures++;
            $display("FAIL basic_out got v=%b d=%h required v=1 d=0100", out_valid, out_data);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || op_cnt !== 8'd1) begin
            failures++;
            $display("FAIL basic_done got v=%b cnt=%0d required v=0 cnt=1", out_valid, op_cnt);
        end
    endtask

    task automatic test_carry;
        logic [W:0] ed;
        logic       es;
`ifdef ADD_OPERAND_SEQ_SAT_EN
        ed = 13'h0FFF;
        es = 1'b1;
`else
        ed = 13'h1000;
        es = 1'b0;
`endif
        out_ready = 1'b1;
        send_pair(12'hFFF, 12'h001);
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== ed || out_sat !== es) begin
            failures++;
            $display("FAIL carry_out got v=%b d=%h s=%b required v=1 d=%h s=%b",
                     out_valid, out_data, out_sat, ed, es);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_stall;
        out_ready = 1'b0;
        send_pair(12'h123, 12'h456);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== 13'h0579 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold cycle=%0d got v=%b d=%h rdy=%b required v=1 d=0579 rdy=0",
                         i, out_valid, out_data, in_ready);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || op_cnt !== 8'd3) begin
            failures++;
            $display("FAIL stall_release got v=%b rdy=%b cnt=%0d required v=0 rdy=1 cnt=3",
                     out_valid, in_ready, op_cnt);
        end
    endtask

    task automatic test_abort;
        out_ready = 1'b1;
        put_beat(12'h0AA);
        in_valid = 1'b1;
        in_data  = 12'h055;
        abort    = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL abort_in_ready got %b required 0", in_ready);
        end
        @(posedge clk);
        #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        send_pair(12'h003, 12'h004);
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 13'h0007) begin
            failures++;
            $display("FAIL abort_next_pair got v=%b d=%h required v=1 d=0007", out_valid, out_data);
        end
        @(posedge clk);
        #1;
        // Abort while a result is offered and out_ready is high: no transfer.
        send_pair(12'h001, 12'h002);
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        void'(exp_q2.pop_back());
        checks++;
        if (out_valid !== 1'b0 || op_cnt !== 8'd4 || out_data !== 13'h0003) begin
            failures++;
            $display("FAIL abort_out got v=%b cnt=%0d d=%h required v=0 cnt=4 d=0003",
                     out_valid, op_cnt, out_data);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            send_pair(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
            @(posedge clk);
            #1;
            @(posedge clk);
            #1;
            if (i == 254) begin
                checks++;
                if (op_cnt !== 8'd255) begin
                    failures++;
                    $display("FAIL b2b_cnt255 got %0d required 255", op_cnt);
                end
            end
        end
        checks++;
        if (op_cnt !== 8'd0) begin
            failures++;
            $display("FAIL b2b_wrap got %0d required 0", op_cnt);
        end
    endtask

    task automatic test_reset_eval;
        out_ready = 1'b1;
        send_pair(12'h005, 12'h006);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_sat, out_data, op_cnt, adder_in} !== '0) begin
            failures++;
            $display("FAIL reset_eval_outputs got v=%b s=%b d=%h c=%h ai=%h required all 0",
                     out_valid, out_sat, out_data, op_cnt, adder_in);
        end
        exp_q2.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_eval_no_result got v=%b required 0", out_valid);
            end
        end
        // Partial pair discarded by reset: next beat must be taken as A.
        put_beat(12'h00A);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        send_pair(12'h008, 12'h009);
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 13'h0011) begin
            failures++;
            $display("FAIL reset_partial got v=%b d=%h required v=1 d=0011", out_valid, out_data);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_stall();
        test_abort();
        test_back_to_back();
        test_reset_eval();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q2.size() != 0) begin
            failures++;
            $display("FAIL sb_drain got %0d pending required 0", exp_q2.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
